// File: rtl/hbridge_guard_pkg.sv
// Shared types and gate patterns for the H-bridge guard.
package hbridge_guard_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    FWD   = 2'd1,
    REV   = 2'd2,
    FAULT = 2'd3
  } state_e;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  localparam logic [3:0] PAT_OFF = 4'b0000;
  localparam logic [3:0] PAT_FWD = 4'b1001;
  localparam logic [3:0] PAT_REV = 4'b0110;

  // Anything that is not an exact forward or reverse pattern is treated as a stop request.
  function automatic state_e decodeReq(input logic [3:0] req);
    case (req)
      PAT_FWD: decodeReq = FWD;
      PAT_REV: decodeReq = REV;
      default: decodeReq = OFF;
    endcase
  endfunction

  function automatic logic [3:0] patternOf(input state_e st);
    case (st)
      FWD:     patternOf = PAT_FWD;
      REV:     patternOf = PAT_REV;
      default: patternOf = PAT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/hbridge_guard_oc_filter.sv
// Two-flop synchronizer for the asynchronous overcurrent flag plus a
// consecutive-low counter that declares an overcurrent after FILTER_CYCLES.
module oc_filter #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic oc_n_i,
  output logic ocSync_o,
  output logic ocDetect_o
);

  localparam int                FILT_W   = $clog2(FILTER_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_CYCLES);

  logic              sync1_q, sync2_q;
  logic [FILT_W-1:0] filtCnt_q, filtCnt_d;

  always_comb begin
    filtCnt_d = filtCnt_q;
    if (sync2_q) begin
      filtCnt_d = '0;
    end else if (filtCnt_q != FILT_MAX) begin
      filtCnt_d = filtCnt_q + FILT_W'(1);
    end
  end

  // Synchronizer flops reset high so a reset never looks like an overcurrent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      filtCnt_q <= '0;
    end else begin
      sync1_q   <= oc_n_i;
      sync2_q   <= sync1_q;
      filtCnt_q <= filtCnt_d;
    end
  end

  assign ocSync_o   = sync2_q;
  assign ocDetect_o = (filtCnt_q == FILT_MAX);

endmodule

// File: rtl/hbridge_guard.sv
// H-bridge gate guard: enforces dead time on direction reversal and latches
// overcurrent faults until a qualified clear.
module hbridge_guard
  import hbridge_guard_pkg::*;
#(
  parameter int DEAD_CYCLES   = 1000,
  parameter int FILTER_CYCLES = 16,
  parameter int HOLD_CYCLES   = 1048576
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] in_req,
  input  logic       oc_n,
  input  logic       fault_clr,
  output logic [3:0] out,
  output logic       fault,
  output logic [7:0] fault_count
);

  localparam int                DEAD_W   = $clog2(DEAD_CYCLES + 1);
  localparam int                HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  state_e            state_q, state_d;
  dir_e              lastDir_q, lastDir_d;
  logic [DEAD_W-1:0] deadCnt_q, deadCnt_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [7:0]        faultCount_q, faultCount_d;
  logic [3:0]        out_q;
  logic              fault_q;

  state_e reqState;
  logic   ocSync, ocDetect;
  logic   deadDone, holdDone;

  oc_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_oc_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .oc_n_i    (oc_n),
    .ocSync_o  (ocSync),
    .ocDetect_o(ocDetect)
  );

  assign reqState = decodeReq(in_req);
  assign deadDone = (deadCnt_q == DEAD_MAX);
  assign holdDone = (holdCnt_q == HOLD_MAX);

  always_comb begin
    state_d      = state_q;
    lastDir_d    = lastDir_q;
    deadCnt_d    = deadCnt_q;
    holdCnt_d    = holdCnt_q;
    faultCount_d = faultCount_q;

    case (state_q)
      OFF: begin
        if (reqState == FWD && (lastDir_q == DIR_FWD || deadDone)) begin
          state_d   = FWD;
          lastDir_d = DIR_FWD;
        end else if (reqState == REV && (lastDir_q == DIR_REV || deadDone)) begin
          state_d   = REV;
          lastDir_d = DIR_REV;
        end
      end
      FWD: if (reqState != FWD) state_d = OFF;
      REV: if (reqState != REV) state_d = OFF;
      FAULT: begin
        if (fault_clr && holdDone && reqState == OFF && ocSync) state_d = OFF;
      end
      default: state_d = OFF;
    endcase

    // Overcurrent overrides whatever the request path decided.
    if (ocDetect) state_d = FAULT;

    if (state_q == OFF) begin
      if (!deadDone) deadCnt_d = deadCnt_q + DEAD_W'(1);
    end else begin
      deadCnt_d = '0;
    end

    if (state_q == FAULT) begin
      if (!holdDone) holdCnt_d = holdCnt_q + HOLD_W'(1);
    end else begin
      holdCnt_d = '0;
    end

    if (state_d == FAULT && state_q != FAULT && faultCount_q != 8'hFF) begin
      faultCount_d = faultCount_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= OFF;
      lastDir_q    <= DIR_FWD;
      deadCnt_q    <= '0;
      holdCnt_q    <= '0;
      faultCount_q <= '0;
      out_q        <= PAT_OFF;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lastDir_q    <= lastDir_d;
      deadCnt_q    <= deadCnt_d;
      holdCnt_q    <= holdCnt_d;
      faultCount_q <= faultCount_d;
      out_q        <= patternOf(state_d);
      fault_q      <= (state_d == FAULT);
    end
  end

  assign out         = out_q;
  assign fault       = fault_q;
  assign fault_count = faultCount_q;

endmodule
